seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern length in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 8, match counter and threshold width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 SHALL have port cfg_ready  output  1  high only in IDLE; a transfer occurs when cfg_valid and cfg_ready are both high at an edge.
REQ-007 SHALL have port cfg_pattern  input  PAT_W  target pattern; MSB is the first bit received.
REQ-008 SHALL have port cfg_thresh  input  CNT_W  match count that ends a run; 0 means the run never ends on count.
REQ-009 SHALL have port start  input  1  begin or restart a run.
REQ-010 SHALL have port stop  input  1  abort to IDLE.
REQ-011 SHALL have port in_valid  input  1  qualifies in_data.
REQ-012 SHALL have port in_data  input  1  serial stream bit.
REQ-013 SHALL have port sq_detected  output  1  one-cycle registered match pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  matches in the current or last run.
REQ-015 SHALL have port irq  output  1  level signal, high in DONE.
REQ-016 SHALL have port state  output  2  IDLE=0, RUN=1, DONE=2; 3 is unused.

Function
REQ-017 FSM: IDLE -> RUN on start, only when a config has been loaded since reset; RUN -> DONE on the threshold match; RUN or DONE -> IDLE on stop; DONE -> RUN on start.
REQ-018 stop SHALL take priority over start when both are high in the same cycle.
REQ-019 A cfg transfer SHALL latch cfg_pattern and cfg_thresh and set an internal cfg_loaded flag; start in IDLE with cfg_loaded low SHALL be ignored.
REQ-020 Entering RUN from IDLE or DONE SHALL clear match_cnt, the history shift register and the fill count in the same edge.
REQ-021 In RUN, each edge with in_valid=1 SHALL shift in_data into the PAT_W-bit history; the fill count SHALL saturate at PAT_W; edges with in_valid=0 change nothing.
REQ-022 A match SHALL occur when the fill count reaches PAT_W and the history, including the bit just accepted, equals the pattern.
REQ-023 sq_detected SHALL go high for exactly one cycle, in the cycle after the edge that accepts the final bit; match_cnt SHALL increment on that same edge.
REQ-024 match_cnt SHALL saturate at 2^CNT_W-1.
REQ-025 When an increment makes match_cnt equal a nonzero cfg_thresh, the FSM SHALL move to DONE on that same edge, with irq high from that edge.
REQ-026 In IDLE and DONE, in_valid and in_data SHALL be ignored; match_cnt SHALL hold until the next entry to RUN.
REQ-027 stop in RUN SHALL preserve match_cnt; a sq_detected pulse already pending SHALL still complete its one cycle.
REQ-028 An in_data value of X or Z with in_valid=0 SHALL have no effect on any state.

Reset
REQ-029 While reset is low: state=IDLE, cfg_ready=1, sq_detected=0, irq=0, match_cnt=0, history=0, fill count=0, cfg_loaded=0, pattern=0, thresh=0.
REQ-030 Reset asserted mid-run SHALL take effect immediately, independent of clk.
REQ-031 The first edge after reset deasserts SHALL behave as a normal IDLE cycle.

Configuration
REQ-032 Macro SEQ_OVERLAP_EN defined: on a match the history and fill count SHALL be retained, so overlapping matches are counted.
REQ-033 Macro SEQ_OVERLAP_EN undefined: on a match the fill count SHALL be cleared, so the next match needs PAT_W newly accepted bits.

Verification
REQ-034 Reset held, then released, then start with no config -> state stays 0, cfg_ready=1, all outputs 0.
REQ-035 Config pattern 5'b10110 with thresh 0, start, stream 1,0,1,1,0 with in_valid=1 -> one sq_detected pulse one cycle after the 5th bit, match_cnt=1, state=1.
REQ-036 Same config, stream 1,0,1,1,0,1,1,0 -> match_cnt=2 with SEQ_OVERLAP_EN defined and match_cnt=1 without it.
REQ-037 Thresh 2, stream 10110 10110 -> state=2 and irq=1 on the second match edge; further input leaves match_cnt=2; then start -> state=1 and match_cnt=0.
REQ-038 Stream 1,0,1 then start and stop together -> state=0 and match_cnt held; then reset pulsed low mid-run -> all outputs 0 asynchronously.
REQ-039 in_valid toggled low with in_data=X between the bits of 10110 -> exactly one match, no X on any output.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with a configurable match threshold and IDLE/RUN/DONE control FSM.
// Optional build macro SEQ_OVERLAP_EN: keep the history on a match so overlapping matches count.
module seq_detect_ctrl #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             sq_detected,
  output logic [CNT_W-1:0] match_cnt,
  output logic             irq,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             st_q, st_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [CNT_W-1:0]   thresh_q, thresh_d;
  logic               loaded_q, loaded_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sq_q, sq_d;

  logic [PAT_W-1:0]   hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic [CNT_W-1:0]   cnt_inc;

  assign hist_shift = {hist_q[PAT_W-2:0], in_data};
  assign fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q      <= IDLE;
      pattern_q <= '0;
      thresh_q  <= '0;
      loaded_q  <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      sq_q      <= 1'b0;
    end else begin
      st_q      <= st_d;
      pattern_q <= pattern_d;
      thresh_q  <= thresh_d;
      loaded_q  <= loaded_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      sq_q      <= sq_d;
    end
  end

  // Config handshake: a transfer happens on any edge where cfg_valid and cfg_ready are both high;
  // cfg_ready is high exactly while the FSM sits in IDLE.
  always_comb begin
    st_d      = st_q;
    pattern_d = pattern_q;
    thresh_d  = thresh_q;
    loaded_d  = loaded_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    sq_d      = 1'b0;
    case (st_q)
      IDLE: begin
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          thresh_d  = cfg_thresh;
          loaded_d  = 1'b1;
        end
        // The registered flag is used, so a start alongside the first config is ignored.
        if (!stop && start && loaded_q) begin
          st_d   = RUN;
          cnt_d  = '0;
          hist_d = '0;
          fill_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          st_d = IDLE;
        end else if (in_valid) begin
          hist_d = hist_shift;
          fill_d = fill_inc;
          if (fill_inc == FILL_FULL && hist_shift == pattern_q) begin
            sq_d = 1'b1;
`ifdef SEQ_OVERLAP_EN
            fill_d = fill_inc;
`else
            fill_d = '0;
`endif
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_inc;
              if (thresh_q != '0 && cnt_inc == thresh_q) st_d = DONE;
            end
          end
        end
      end
      DONE: begin
        if (stop) begin
          st_d = IDLE;
        end else if (start) begin
          st_d   = RUN;
          cnt_d  = '0;
          hist_d = '0;
          fill_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign state       = st_q;
  assign cfg_ready   = (st_q == IDLE);
  assign irq         = (st_q == DONE);
  assign sq_detected = sq_q;
  assign match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed scenarios plus random traffic against a
// bit-queue reference model; honours SEQ_OVERLAP_EN the same way as the design.
module tb_seq_detect_ctrl;
  localparam int PAT_W = 5;
  localparam int CNT_W = 4;
  localparam int OW    = 5 + CNT_W;
`ifdef SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [CNT_W-1:0] cfg_thresh = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_data = 1'b0;
  logic             sq_detected;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic [1:0]       state;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_thresh(cfg_thresh), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .sq_detected(sq_detected),
    .match_cnt(match_cnt), .irq(irq), .state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  // reference model: state names as integers, accepted bits kept in a queue
  int m_state = 0;
  bit m_loaded = 0;
  int m_pat = 0;
  int m_th = 0;
  int m_cnt = 0;
  bit m_sq = 0;
  bit m_bits[$];
  int m_since = 0;

  function automatic logic [OW-1:0] pack(input int st, input bit sq, input int cnt);
    logic [1:0] s2;
    logic [CNT_W-1:0] c;
    s2 = st[1:0];
    c  = cnt[CNT_W-1:0];
    return {s2, (st == 0), sq, (st == 2), c};
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {state, cfg_ready, sq_detected, irq, match_cnt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_loaded = 0; m_pat = 0; m_th = 0; m_cnt = 0; m_sq = 0;
    m_bits.delete(); m_since = 0;
  endtask

  task automatic model_begin_run();
    m_state = 1; m_cnt = 0; m_bits.delete(); m_since = 0;
  endtask

  task automatic model_step(input bit cv, input int cp, input int ct, input bit st,
                            input bit sp, input bit iv, input bit id);
    int v;
    m_sq = 0;
    if (m_state == 0) begin
      bit was_loaded = m_loaded;
      if (cv) begin m_pat = cp; m_th = ct; m_loaded = 1; end
      if (!sp && st && was_loaded) model_begin_run();
    end else if (m_state == 1) begin
      if (sp) m_state = 0;
      else if (iv) begin
        m_bits.push_back(id);
        m_since++;
        if (m_since >= PAT_W) begin
          v = 0;
          for (int i = 0; i < PAT_W; i++) v = (v << 1) | int'(m_bits[m_bits.size() - PAT_W + i]);
          if (v == m_pat) begin
            m_sq = 1;
            if (!OVL) m_since = 0;
            if (m_cnt < (1 << CNT_W) - 1) begin
              m_cnt++;
              if (m_th != 0 && m_cnt == m_th) m_state = 2;
            end
          end
        end
      end
    end else begin
      if (sp) m_state = 0;
      else if (st) model_begin_run();
    end
  endtask

  // driver: apply one cycle of inputs at the falling edge and queue the post-edge expectation
  task automatic cycle(input logic cv, input logic [PAT_W-1:0] cp, input logic [CNT_W-1:0] ct,
                       input logic st, input logic sp, input logic iv, input logic id);
    @(negedge clk);
    cfg_valid = cv; cfg_pattern = cp; cfg_thresh = ct;
    start = st; stop = sp; in_valid = iv; in_data = id;
    model_step(cv, int'(cp), int'(ct), st, sp, iv, (id === 1'b1));
    exp_q.push_back(pack(m_state, m_sq, m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, '0, 0, 0, 0, 0);
  endtask

  task automatic configure(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] t);
    cycle(1, p, t, 0, 0, 0, 0);
  endtask

  task automatic stream(input logic [15:0] v, input int n);
    logic [15:0] w;
    w = v;
    for (int i = n - 1; i >= 0; i--) cycle(0, '0, '0, 0, 0, 1, w[i]);
  endtask

  task automatic direct_check(input string name, input logic [OW-1:0] e);
    logic [OW-1:0] g;
    g = dut_out();
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, g, e);
    end
  endtask

  // monitor: compares DUT outputs with the queued expectation after every active edge
  initial begin
    logic [OW-1:0] e;
    logic [OW-1:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_out();
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL out_vec t=%0t got={st,rdy,sq,irq,cnt}=%h exp=%h", $time, g, e);
        end
      end
    end
  end

  initial begin
    logic [PAT_W-1:0] pats[5];
    pats[0] = 5'b10110; pats[1] = 5'b11111; pats[2] = 5'b00000; pats[3] = 5'b10101; pats[4] = 5'b01001;

    // reset held: outputs at reset values regardless of clock
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      direct_check("reset_hold", pack(0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // start without any config is ignored
    cycle(0, '0, '0, 1, 0, 0, 0);
    cycle(0, '0, '0, 1, 0, 1, 1);
    idle(1);

    // single match, thresh 0
    configure(5'b10110, 4'd0);
    cycle(0, '0, '0, 1, 0, 0, 0);
    stream(16'b10110, 5);
    idle(2);

    // overlapping stream after a fresh run
    cycle(0, '0, '0, 0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0, 0);
    stream(16'b10110110, 8);
    idle(1);

    // threshold 2 ends the run; further input ignored; restart clears
    cycle(0, '0, '0, 0, 1, 0, 0);
    configure(5'b10110, 4'd2);
    cycle(0, '0, '0, 1, 0, 0, 0);
    stream(16'b1011010110, 10);
    stream(16'b10110, 5);
    cycle(0, '0, '0, 1, 0, 0, 0);

    // partial stream, then start+stop together: stop wins, count held
    stream(16'b101, 3);
    cycle(0, '0, '0, 1, 1, 0, 0);
    idle(2);

    // mid-run asynchronous reset
    cycle(0, '0, '0, 1, 0, 0, 0);
    stream(16'b10110, 5);
    idle(1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    direct_check("async_reset", pack(0, 0, 0));
    model_reset();
    @(negedge clk);
    direct_check("reset_low_negedge", pack(0, 0, 0));
    reset = 1'b1;

    // gaps with in_valid low and in_data X
    configure(5'b10110, 4'd0);
    cycle(0, '0, '0, 1, 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 0, 1'bx);
    cycle(0, '0, '0, 0, 0, 1, 0);
    cycle(0, '0, '0, 0, 0, 0, 1'bx);
    cycle(0, '0, '0, 0, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 0, 1'bx);
    cycle(0, '0, '0, 0, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 0, 1'bx);
    cycle(0, '0, '0, 0, 0, 1, 0);
    cycle(0, '0, '0, 0, 0, 0, 1'bx);
    idle(1);

    // counter saturation with an all-ones pattern
    cycle(0, '0, '0, 0, 1, 0, 0);
    configure(5'b11111, 4'd0);
    cycle(0, '0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, '0, '0, 0, 0, 1, 1);
    cycle(0, '0, '0, 0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (m_state == 0) begin
        cycle($urandom_range(0, 1), pats[$urandom_range(0, 4)], 4'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
              $urandom_range(0, 1));
      end else if (m_state == 1) begin
        cycle($urandom_range(0, 1), pats[$urandom_range(0, 4)], 4'($urandom_range(0, 3)),
              0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7), $urandom_range(0, 1));
      end else begin
        cycle($urandom_range(0, 1), pats[$urandom_range(0, 4)], 4'($urandom_range(0, 3)),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
              $urandom_range(0, 1));
      end
    end
    idle(2);

    @(posedge clk); #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
